// File: rtl/mdu_iter_param_pkg.sv
// mdu_defs: shared definitions for the iterative multiply/divide unit.
//   - op code constants (4-bit, codes 11-15 are treated as NONE)
//   - FSM state encoding
//   - div_latency(): busy cycles of a divide for a given width/step
package mdu_defs;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX
  } mdu_state_t;

  // One prep cycle, WIDTH/DIV_STEP iteration cycles, one fix/commit cycle.
  function automatic int unsigned div_latency(input int unsigned width,
                                              input int unsigned step);
    return width / step + 2;
  endfunction

endpackage

// File: rtl/mdu_iter_param_if.sv
// mdu_iter_param_if: E-stage issue/result bundle of the multiply/divide unit.
//   start/op/d1/d2/cancel : issue side (driven by the pipeline, master)
//   busy/hi_rd/lo_rd/div_zero : status and HI/LO read side (driven by the unit, slave)
interface mdu_iter_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi_rd;
  logic [WIDTH-1:0] lo_rd;
  logic             div_zero;

  modport master (
    output start, op, d1, d2, cancel,
    input  busy, hi_rd, lo_rd, div_zero
  );

  modport slave (
    input  start, op, d1, d2, cancel,
    output busy, hi_rd, lo_rd, div_zero
  );
endinterface

// File: rtl/mdu_iter_param_div_core.sv
// mdu_div_core: unsigned restoring divider, DIV_STEP quotient bits per cycle.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture dividend/divisor and start WIDTH/DIV_STEP iterations
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor (0 yields garbage; caller handles it)
//   done       : no iterations outstanding
//   quot, rem  : quotient and remainder, valid when done after a load
module mdu_div_core
  import mdu_defs::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DIV_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned ITERS = WIDTH / DIV_STEP;
  localparam int unsigned CW    = $clog2(ITERS + 1);

  logic [WIDTH-1:0] q_r, r_r, dv_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   r_t;
  logic [WIDTH-1:0] q_t;

  // The quotient register doubles as the dividend shift register: dividend
  // bits leave at the top while quotient bits enter at the bottom.
  always_comb begin
    r_t = {1'b0, r_r};
    q_t = q_r;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
      q_t = {q_t[WIDTH-2:0], 1'b0};
      if (r_t >= {1'b0, dv_r}) begin
        r_t     = r_t - {1'b0, dv_r};
        q_t[0]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= '0;
      r_r   <= '0;
      dv_r  <= '0;
      cnt_r <= '0;
    end else if (load) begin
      q_r   <= dividend;
      r_r   <= '0;
      dv_r  <= divisor;
      cnt_r <= CW'(ITERS);
    end else if (cnt_r != '0) begin
      q_r   <= q_t;
      r_r   <= r_t[WIDTH-1:0];
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign done = (cnt_r == '0);
  assign quot = q_r;
  assign rem  = r_r;

endmodule

// File: rtl/mdu_iter_param.sv
// mdu_iter_param: E-stage multiply/divide unit owning HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mdu_iter_param_if
//                start/op/d1/d2 issue an op when idle and cancel=0;
//                cancel aborts an in-flight op (no HI/LO write);
//                busy is high while an op is in flight;
//                hi_rd/lo_rd are the HI/LO registers (no bypass);
//                div_zero pulses for one cycle after a divide-by-zero completes.
module mdu_iter_param
  import mdu_defs::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_STEP    = 4
) (
  input logic              clk,
  input logic              reset,
  mdu_iter_param_if.slave  bus
);

  localparam int unsigned ITERS   = div_latency(WIDTH, DIV_STEP) - 2;
  localparam int unsigned CNT_MAX = (MULT_CYCLES > ITERS) ? MULT_CYCLES : ITERS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  mdu_state_t state, state_n;

  logic [WIDTH-1:0]   hi, lo;
  logic               div_zero_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic               acc_r, sub_r;
  logic [WIDTH-1:0]   opa, opb;
  logic               sgn_r, q_neg, r_neg;

  logic issue_mul, issue_div, wr_hi, wr_lo, div_load, commit_mul, commit_div;
  logic op_signed, op_acc, op_sub;

  logic [2*WIDTH-1:0] ext_a, ext_b, hilo_next;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               core_done;
  logic [WIDTH-1:0]   core_quot, core_rem;

  // Operation class decode of the issuing op.
  always_comb begin
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    op_acc    = (bus.op == OP_MADD) || (bus.op == OP_MADDU) ||
                (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
    op_sub    = (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    issue_mul  = 1'b0;
    issue_div  = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    div_load   = 1'b0;
    commit_mul = 1'b0;
    commit_div = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              issue_mul = 1'b1;
              state_n   = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              issue_div = 1'b1;
              state_n   = ST_DIV_PREP;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (bus.cancel) begin
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          commit_mul = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      ST_DIV_PREP: begin
        if (bus.cancel) begin
          state_n = ST_IDLE;
        end else begin
          div_load = 1'b1;
          state_n  = ST_DIV_ITER;
        end
      end
      ST_DIV_ITER: begin
        if (bus.cancel)       state_n = ST_IDLE;
        else if (cnt == '0)   state_n = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        state_n    = ST_IDLE;
        commit_div = !bus.cancel && core_done;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Extending both operands to 2*WIDTH makes one truncated multiply serve
  // both signed and unsigned forms.
  always_comb begin
    ext_a = op_signed ? {{WIDTH{bus.d1[WIDTH-1]}}, bus.d1} : {{WIDTH{1'b0}}, bus.d1};
    ext_b = op_signed ? {{WIDTH{bus.d2[WIDTH-1]}}, bus.d2} : {{WIDTH{1'b0}}, bus.d2};
    abs_a = (sgn_r && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    abs_b = (sgn_r && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;
    if (!acc_r)     hilo_next = prod;
    else if (sub_r) hilo_next = {hi, lo} - prod;
    else            hilo_next = {hi, lo} + prod;
  end

  mdu_div_core #(
    .WIDTH    (WIDTH),
    .DIV_STEP (DIV_STEP)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (core_done),
    .quot     (core_quot),
    .rem      (core_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= '0;
      lo         <= '0;
      div_zero_r <= 1'b0;
      cnt        <= '0;
      prod       <= '0;
      acc_r      <= 1'b0;
      sub_r      <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      sgn_r      <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      div_zero_r <= 1'b0;
      if (wr_hi) hi <= bus.d1;
      if (wr_lo) lo <= bus.d1;
      if (issue_mul) begin
        prod  <= ext_a * ext_b;
        acc_r <= op_acc;
        sub_r <= op_sub;
        cnt   <= CW'(MULT_CYCLES - 1);
      end else if (div_load) begin
        cnt <= CW'(ITERS - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (issue_div) begin
        opa   <= bus.d1;
        opb   <= bus.d2;
        sgn_r <= op_signed;
      end
      if (div_load) begin
        q_neg <= sgn_r && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg <= sgn_r && opa[WIDTH-1];
      end
      if (commit_mul) {hi, lo} <= hilo_next;
      if (commit_div) begin
        if (opb == '0) begin
          div_zero_r <= 1'b1;
        end else begin
          lo <= q_neg ? (~core_quot + WIDTH'(1)) : core_quot;
          hi <= r_neg ? (~core_rem + WIDTH'(1)) : core_rem;
        end
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.hi_rd    = hi;
  assign bus.lo_rd    = lo;
  assign bus.div_zero = div_zero_r;

endmodule

// File: tb/tb_mdu_iter_param.sv
// Directed bench for mdu_iter_param: a default-parameter instance (A) and a
// WIDTH=16/MULT_CYCLES=1/DIV_STEP=2 instance (B), selected by 'sel'.
module tb_mdu_iter_param;
  import mdu_defs::*;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  always #5 clk = ~clk;

  mdu_iter_param_if #(.WIDTH(32)) ifa ();
  mdu_iter_param_if #(.WIDTH(16)) ifb ();

  mdu_iter_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_STEP(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  mdu_iter_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_STEP(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        busy_o, dz_o;
  logic [31:0] hi_o, lo_o;
  assign busy_o = sel ? ifb.busy : ifa.busy;
  assign dz_o   = sel ? ifb.div_zero : ifa.div_zero;
  assign hi_o   = sel ? {16'h0, ifb.hi_rd} : ifa.hi_rd;
  assign lo_o   = sel ? {16'h0, ifb.lo_rd} : ifa.lo_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic cn);
    ifa.start  = sel ? 1'b0 : st;
    ifa.op     = o;
    ifa.d1     = a;
    ifa.d2     = b;
    ifa.cancel = sel ? 1'b0 : cn;
    ifb.start  = sel ? st : 1'b0;
    ifb.op     = o;
    ifb.d1     = a[15:0];
    ifb.d2     = b[15:0];
    ifb.cancel = sel ? cn : 1'b0;
  endtask

  // Issue at edge T, expect busy for T+1..T+lat, results visible at T+lat+1.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    drive(1'b1, o, a, b, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    for (int i = 1; i <= lat; i++) begin
      check({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
      tick();
    end
    check({tag, "_idle"}, {31'h0, busy_o}, 32'h0);
    check({tag, "_hi"}, hi_o, ehi);
    check({tag, "_lo"}, lo_o, elo);
    check({tag, "_dz"}, {31'h0, dz_o}, {31'h0, edz});
  endtask

  task automatic mt(input string tag, input logic [3:0] o, input logic [31:0] v);
    drive(1'b1, o, v, '0, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    check({tag, "_nobusy"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    sel   = 1'b0;
    reset = 1'b1;
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_dz", {31'h0, dz_o}, 32'h0);

    run_op("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",  OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'h0, 1'b0);
    run_op("minint", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);

    mt("mthi", OP_MTHI, 32'h1234_5678);
    check("mthi_hi", hi_o, 32'h1234_5678);
    mt("mtlo", OP_MTLO, 32'h1);
    check("mtlo_lo", lo_o, 32'h1);
    run_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 5, 32'h1234_5679, 32'hFFFF_FFFF, 1'b0);
    run_op("msub",  OP_MSUB,  32'd1, 32'd1, 5, 32'h1234_5679, 32'hFFFF_FFFE, 1'b0);

    mt("mthi5", OP_MTHI, 32'd5);
    mt("mtlo6", OP_MTLO, 32'd6);
    run_op("divz", OP_DIV, 32'd9, 32'd0, 10, 32'd5, 32'd6, 1'b1);
    tick();
    check("divz_pulse_end", {31'h0, dz_o}, 32'h0);

    // Cancel a divide during cycle T+4.
    drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b1);
    check("cdiv_busy_t4", {31'h0, busy_o}, 32'h1);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    check("cdiv_idle_t5", {31'h0, busy_o}, 32'h0);
    repeat (12) tick();
    check("cdiv_hi", hi_o, 32'd5);
    check("cdiv_lo", lo_o, 32'd6);
    check("cdiv_dz", {31'h0, dz_o}, 32'h0);

    // Start together with cancel is dropped, including MTHI.
    drive(1'b1, OP_MULT, 32'd2, 32'd3, 1'b1);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    check("cstart_busy", {31'h0, busy_o}, 32'h0);
    repeat (7) tick();
    check("cstart_lo", lo_o, 32'd6);
    drive(1'b1, OP_MTHI, 32'hAA, '0, 1'b1);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    check("cmthi_hi", hi_o, 32'd5);

    // Start while busy is ignored.
    drive(1'b1, OP_MULT, 32'd7, 32'd6, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    tick();
    drive(1'b1, OP_DIV, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    tick();
    tick();
    check("sbusy_t5", {31'h0, busy_o}, 32'h1);
    tick();
    check("sbusy_t6", {31'h0, busy_o}, 32'h0);
    check("sbusy_hi", hi_o, 32'h0);
    check("sbusy_lo", lo_o, 32'd42);
    tick();
    check("sbusy_nolate", {31'h0, busy_o}, 32'h0);

    // Cancel in the commit cycle.
    drive(1'b1, OP_MULT, 32'd3, 32'd3, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    repeat (4) tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b1);
    check("ccommit_busy", {31'h0, busy_o}, 32'h1);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    check("ccommit_idle", {31'h0, busy_o}, 32'h0);
    check("ccommit_lo", lo_o, 32'd42);

    // Reset in T+3 of a multiply.
    mt("mthi77", OP_MTHI, 32'h77);
    drive(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
    tick();
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", {31'h0, busy_o}, 32'h0);
    check("mrst_hi", hi_o, 32'h0);
    check("mrst_lo", lo_o, 32'h0);
    repeat (5) tick();
    check("mrst_late_lo", lo_o, 32'h0);
    check("mrst_late_busy", {31'h0, busy_o}, 32'h0);

    // Small configuration.
    sel = 1'b1;
    drive(1'b0, OP_NONE, '0, '0, 1'b0);
    run_op("b_mult",  OP_MULT,  32'hFFFE, 32'd3, 1, 32'hFFFF, 32'hFFFA, 1'b0);
    run_op("b_multu", OP_MULTU, 32'hFFFE, 32'd3, 1, 32'h0002, 32'hFFFA, 1'b0);
    run_op("b_div",   OP_DIV,   32'hFFF9, 32'd2, 10, 32'hFFFF, 32'hFFFD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
